// File: rtl/ov7670_capture_scaled.sv
// OV7670 byte-pair capture: assembles 12-bit pixels, decimates by 2^ds in x/y, writes a linear frame buffer.
// Optional CAPTURE_HAVG_EN: horizontal box average over each 2^ds run instead of point sampling.
module ov7670_capture_scaled #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned MAX_DS = 3
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  input  logic              capture_en,
  input  logic [1:0]        mode,
  input  logic [1:0]        ds,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              we,
  output logic              frame_done,
  output logic              overflow,
  output logic [9:0]        line_cnt
);

  localparam int unsigned COL_W = $clog2(WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 1);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [1:0]  DS_MAX = (MAX_DS > 3) ? 2'd3 : 2'(MAX_DS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic              r_vsync_d;
  logic              r_href_d;
  logic              r_phase;
  logic [7:0]        r_b0;
  logic [1:0]        r_mode;
  logic [1:0]        r_ds;
  logic [CNT_W-1:0]  r_limit;
  logic [CNT_W-1:0]  r_count;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dout;
  logic              r_we;
  logic              r_overflow;
  logic [9:0]        r_line_cnt;

  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_href_fall;
  logic              w_pix_stb;
  logic [1:0]        w_ds_clamp;
  logic [COL_W-1:0]  w_cmask;
  logic [ROW_W-1:0]  w_rmask;
  logic              w_in_range;
  logic              w_keep;
  logic [DATA_W-1:0] w_pix;

  function automatic logic [CNT_W-1:0] f_limit(input logic [1:0] d);
    int unsigned w_cols;
    int unsigned w_rows;
    w_cols = WIDTH >> d;
    w_rows = HEIGHT >> d;
    return CNT_W'(w_cols * w_rows);
  endfunction

  assign w_vs_rise   = vsync & ~r_vsync_d;
  assign w_vs_fall   = ~vsync & r_vsync_d;
  assign w_href_fall = ~href & r_href_d;
  assign w_pix_stb   = (r_state == S_ACTIVE) && href && r_phase && !w_vs_rise;
  assign w_ds_clamp  = (ds > DS_MAX) ? DS_MAX : ds;
  assign w_cmask     = ~({COL_W{1'b1}} << r_ds);
  assign w_rmask     = ~({ROW_W{1'b1}} << r_ds);
  assign w_in_range  = (r_col < COL_W'(WIDTH)) && (r_row < ROW_W'(HEIGHT));

`ifdef CAPTURE_HAVG_EN
  logic [10:0] r_acc0;
  logic [6:0]  r_acc1;
  logic [6:0]  r_acc2;
  logic [10:0] w_c0;
  logic [6:0]  w_c1;
  logic [6:0]  w_c2;
  logic [10:0] w_sum0;
  logic [6:0]  w_sum1;
  logic [6:0]  w_sum2;
  logic [7:0]  w_avg0;
  logic [3:0]  w_avg1;
  logic [3:0]  w_avg2;
  logic        w_run_first;

  assign w_run_first = ((r_col & w_cmask) == '0);

  always_comb begin
    w_c0 = '0;
    w_c1 = '0;
    w_c2 = '0;
    case (r_mode)
      2'd1: begin
        w_c0 = 11'(r_b0[7:4]);
        w_c1 = 7'({r_b0[2:0], din[7]});
        w_c2 = 7'(din[4:1]);
      end
      2'd2:    w_c0 = 11'(r_b0);
      default: begin
        w_c0 = 11'(r_b0[7:4]);
        w_c1 = 7'(r_b0[7:4]);
        w_c2 = 7'(r_b0[7:4]);
      end
    endcase
    w_sum0 = w_run_first ? w_c0 : r_acc0 + w_c0;
    w_sum1 = w_run_first ? w_c1 : r_acc1 + w_c1;
    w_sum2 = w_run_first ? w_c2 : r_acc2 + w_c2;
    w_avg0 = 8'(w_sum0 >> r_ds);
    w_avg1 = 4'(w_sum1 >> r_ds);
    w_avg2 = 4'(w_sum2 >> r_ds);
    case (r_mode)
      2'd1:    w_pix = {w_avg0[3:0], w_avg1, w_avg2};
      2'd2:    w_pix = {4'h0, w_avg0};
      default: w_pix = {w_avg0[3:0], w_avg0[3:0], w_avg0[3:0]};
    endcase
  end

  // Write on the last pixel of a run; a run cut short by line end never reaches it.
  assign w_keep = w_in_range && ((r_col & w_cmask) == w_cmask) && ((r_row & w_rmask) == '0);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
      r_acc2 <= '0;
    end else if (w_pix_stb) begin
      r_acc0 <= w_sum0;
      r_acc1 <= w_sum1;
      r_acc2 <= w_sum2;
    end
  end
`else
  always_comb begin
    case (r_mode)
      2'd1:    w_pix = {r_b0[7:4], r_b0[2:0], din[7], din[4:1]};
      2'd2:    w_pix = {4'h0, r_b0};
      default: w_pix = {r_b0[7:4], r_b0[7:4], r_b0[7:4]};
    endcase
  end

  assign w_keep = w_in_range && ((r_col & w_cmask) == '0) && ((r_row & w_rmask) == '0);
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vsync_d  <= 1'b0;
      r_href_d   <= 1'b0;
      r_phase    <= 1'b0;
      r_b0       <= '0;
      r_mode     <= '0;
      r_ds       <= '0;
      r_limit    <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_we       <= 1'b0;
      r_overflow <= 1'b0;
      r_line_cnt <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_href_d  <= href;
      r_phase   <= href ? ~r_phase : 1'b0;
      if (href && !r_phase) r_b0 <= din;
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: if (vsync) r_state <= S_WAIT_VS;
        S_WAIT_VS: begin
          if (w_vs_fall && capture_en) begin
            r_state    <= S_ACTIVE;
            r_mode     <= mode;
            r_ds       <= w_ds_clamp;
            r_limit    <= f_limit(w_ds_clamp);
            r_count    <= '0;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_line_cnt <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_vs_rise) begin
            r_state <= S_DONE;
          end else begin
            if (w_pix_stb) begin
              if (r_col != '1) r_col <= r_col + 1'b1;
              if (w_keep) begin
                if (r_count == r_limit) begin
                  r_overflow <= 1'b1;
                end else begin
                  r_we    <= 1'b1;
                  r_addr  <= r_count[ADDR_W-1:0];
                  r_dout  <= w_pix;
                  r_count <= r_count + 1'b1;
                end
              end
            end
            if (w_href_fall) begin
              r_col <= '0;
              if (r_row != '1) r_row <= r_row + 1'b1;
              if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_WAIT_VS;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr       = r_addr;
  assign dout       = r_dout;
  assign we         = r_we;
  assign frame_done = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign line_cnt   = r_line_cnt;

endmodule
